// File: rtl/seg_seq_pkg.sv
// Shared types and constants for the segment-display animation sequencer.
package seg_seq_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL    = 2'd0,
    ST_AUTO_LOAD = 2'd1,
    ST_AUTO_PLAY = 2'd2
  } state_t;

  // Playlist entry as written on the config bus: {repeats-1, animation}.
  typedef struct packed {
    logic [1:0] reps;
    logic [5:0] anim;
  } slot_t;

  localparam logic [3:0] ADDR_LEN     = 4'd8;
  localparam logic [3:0] ADDR_PERIOD  = 4'd9;
  localparam logic [7:0] PERIOD_RST   = 8'd99;
  localparam int         PRESCALE_DEF = 100_000;

endpackage

// File: rtl/seg_seq_timebase.sv
// Frame timebase: PRESCALE-cycle prescaler feeding a (period+1) unit counter.
module seg_seq_timebase
  import seg_seq_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       restart,
  input  logic [7:0] period,
  output logic       tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;
  logic [7:0]    per;
  logic          pre_end;

  assign pre_end = (pre == PW'(PRESCALE - 1));
  // >= keeps the count bounded if period is lowered mid-frame.
  assign tick    = ena && !restart && pre_end && (per >= period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      per <= '0;
    end else if (restart) begin
      pre <= '0;
      per <= '0;
    end else if (ena) begin
      if (pre_end) begin
        pre <= '0;
        per <= (per >= period) ? 8'd0 : per + 8'd1;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/seg_show_sequencer.sv
// Animation sequencer: manual stepping or playlist-driven auto play for a
// segment display decoder.
module seg_show_sequencer
  import seg_seq_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_mode,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic [5:0] frame_limit,
  output logic [5:0] animation,
  output logic [5:0] digit,
  output logic       frame_tick,
  output logic       auto_mode,
  output logic [2:0] play_idx
);

  slot_t      playlist [8];
  logic [2:0] len;
  logic [7:0] period;
  state_t     state;
  logic [1:0] loop_cnt;
  logic [1:0] reps;
  logic       tick;
  logic       restart;
  logic       wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) playlist[i] <= '0;
      len    <= '0;
      period <= PERIOD_RST;
    end else if (cfg_we) begin
      if (!cfg_addr[3])                playlist[cfg_addr[2:0]] <= slot_t'(cfg_data);
      else if (cfg_addr == ADDR_LEN)    len    <= cfg_data[2:0];
      else if (cfg_addr == ADDR_PERIOD) period <= cfg_data;
    end
  end

  // Restart the frame timer whenever the animation changes so every
  // animation starts on a full frame.
  assign restart = ena && ((state == ST_MANUAL && !btn_mode && (btn_next || btn_prev))
                           || state == ST_AUTO_LOAD);
  assign wrap    = (digit >= frame_limit);

  seg_seq_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .restart (restart),
    .period  (period),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_MANUAL;
      animation  <= '0;
      digit      <= '0;
      frame_tick <= 1'b0;
      auto_mode  <= 1'b0;
      play_idx   <= '0;
      loop_cnt   <= '0;
      reps       <= '0;
    end else begin
      frame_tick <= tick;
      if (ena) begin
        if (tick) digit <= wrap ? 6'd0 : digit + 6'd1;
        case (state)
          ST_MANUAL: begin
            if (btn_mode) begin
              state     <= ST_AUTO_LOAD;
              auto_mode <= 1'b1;
              play_idx  <= '0;
            end else if (btn_next) begin
              animation <= animation + 6'd1;
              digit     <= '0;
            end else if (btn_prev) begin
              animation <= animation - 6'd1;
              digit     <= '0;
            end
          end
          // Slot contents are latched here, so edits to the active slot
          // only show up on the next load.
          ST_AUTO_LOAD: begin
            animation <= playlist[play_idx].anim;
            reps      <= playlist[play_idx].reps;
            loop_cnt  <= '0;
            digit     <= '0;
            state     <= ST_AUTO_PLAY;
          end
          ST_AUTO_PLAY: begin
            if (btn_mode) begin
              state     <= ST_MANUAL;
              auto_mode <= 1'b0;
            end else if (tick && wrap) begin
              if (loop_cnt == reps) begin
                play_idx <= (play_idx >= len) ? 3'd0 : play_idx + 3'd1;
                state    <= ST_AUTO_LOAD;
              end else begin
                loop_cnt <= loop_cnt + 2'd1;
              end
            end
          end
          default: begin
            state     <= ST_MANUAL;
            auto_mode <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/seg_show_sequencer.md
SEG_SHOW_SEQUENCER -- requirements
Module: seg_show_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 100_000, meaning clk cycles per timebase unit (10 ms at 10 MHz).
REQ-002 SHALL have ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  block enable
- btn_next  in  1  one-shot pulse, next animation
- btn_prev  in  1  one-shot pulse, previous animation
- btn_mode  in  1  one-shot pulse, toggle MANUAL/AUTO
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  config address
- cfg_data  in  8  config write data
- frame_limit  in  6  last frame index of the current animation
- animation  out  6  animation select to the display decoder
- digit  out  6  frame index to the display decoder
- frame_tick  out  1  one-cycle frame-advance pulse
- auto_mode  out  1  high in AUTO
- play_idx  out  3  current playlist slot

Function
REQ-003 SHALL use only clk and rst_n (single clock domain, async active-low reset); all outputs registered.
REQ-004 SHALL hold config registers: playlist[0..7] (addr 0-7: data[5:0] animation, data[7:6] repeats-1), len (addr 8: data[2:0] = entries-1), period (addr 9: data[7:0] = units-1); writes to addr 10-15 ignored.
REQ-005 SHALL accept cfg_we writes in the next cycle regardless of ena or mode.
REQ-006 SHALL, while ena=1, pulse frame_tick for exactly one cycle every (period+1)*PRESCALE cycles; ena=0 freezes the prescaler, period counter, digit, animation, state and play_idx, and ignores buttons.
REQ-007 SHALL, on frame_tick, set digit to digit+1, or to 0 when digit >= frame_limit; the latter is a loop completion.
REQ-008 SHALL implement FSM states MANUAL, AUTO_LOAD, AUTO_PLAY.
REQ-009 MANUAL: btn_next sets animation+1 (63 wraps to 0); btn_prev sets animation-1 (0 wraps to 63); on either change, digit clears to 0 and the frame timer restarts.
REQ-010 MANUAL + btn_mode goes to AUTO_LOAD with play_idx=0.
REQ-011 AUTO_LOAD (one cycle): animation <= playlist[play_idx][5:0], loop counter <= 0, digit <= 0, timer restarts; then AUTO_PLAY.
REQ-012 AUTO_PLAY: on loop completion with loop counter == repeats-1, play_idx advances (to 0 if play_idx >= len) and the FSM goes to AUTO_LOAD; otherwise the loop counter increments.
REQ-013 AUTO_PLAY ignores btn_next/btn_prev; btn_mode goes to MANUAL, keeping animation and digit.
REQ-014 Simultaneous pulses: btn_mode beats btn_next, which beats btn_prev; only one action per cycle.
REQ-015 A playlist write to the active slot SHALL take effect at the next AUTO_LOAD only; lowering len below play_idx SHALL wrap to 0 at the next advance.
REQ-016 auto_mode SHALL be 1 in AUTO_LOAD and AUTO_PLAY.

Reset
REQ-017 rst_n low SHALL immediately set: animation=0, digit=0, frame_tick=0, auto_mode=0, play_idx=0, state MANUAL, len=0, period=99, all playlist entries 0, loop counter, prescaler and period counter 0.
REQ-018 Reset mid-operation (any state) SHALL return to the REQ-017 values with no residual pulse after release.

Structure
REQ-019 Package seg_seq_pkg SHALL hold the FSM state encoding, cfg address constants (ADDR_LEN=8, ADDR_PERIOD=9), reset constants (PERIOD_RST=99) and the PRESCALE default.
REQ-020 Prescaler and period counter SHALL be a sub-module seg_seq_timebase (inputs ena, restart, period; output tick).

Verification (PRESCALE=4)
REQ-021 Write period=1, set ena=1, and wait -> frame_tick every 8 cycles; digit 0..frame_limit(=3) then 0.
REQ-022 In MANUAL at animation=0, pulse btn_prev -> animation=63 and digit=0; pulse btn_next -> animation=0.
REQ-023 Program slot0={anim 5, rep 2}, slot1={anim 9, rep 1}, len=1, frame_limit=1, then pulse btn_mode -> animation=5 for 4 ticks, 9 for 2 ticks, back to 5; play_idx 0,1,0.
REQ-024 Pulse btn_mode and btn_next in the same cycle from MANUAL -> AUTO entered; animation=playlist[0], not incremented.
REQ-025 Set ena=0 for 20 cycles mid-frame -> no frame_tick and all outputs stable; resumes with the remaining count.
REQ-026 Assert rst_n low in AUTO_PLAY with play_idx=1 -> all outputs and config return to reset values asynchronously.
